// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
//
// Purpose:
//   Read-side drain adapter for async_fifo, clocked in the rclk domain.
//   It pops words from the FIFO read port and presents them as a registered
//   valid/ready stream. A 2-entry skid buffer (head + skid) lets the stream
//   run at 1 word/cycle while keeping m_ready out of the rinc path. m_last
//   marks every PKT_LEN-th transferred word.
//
// Parameters:
//   DSIZE   - data width, matches async_fifo DSIZE
//   PKT_LEN - words per packet for m_last generation (1..65535)
//
// Ports:
//   rclk      in   read-domain clock
//   rrst_n    in   asynchronous active-low reset
//   en        in   drain enable; 0 stops popping, buffered words still drain
//   flush     in   synchronous discard of buffered words and packet counter
//   rempty    in   FIFO empty flag
//   rdata     in   FIFO head word, valid whenever rempty=0
//   rinc      out  FIFO pop strobe
//   m_valid   out  stream word valid
//   m_ready   in   downstream accept
//   m_data    out  stream word
//   m_last    out  last word of a PKT_LEN packet
//   level     out  skid-buffer occupancy 0..2
//   pop_cnt   out  (ASYNC_FIFO_RD_STATS_EN only) saturating count of pops
//   stall_cnt out  (ASYNC_FIFO_RD_STATS_EN only) saturating count of stalls
//
// Optional feature macro: ASYNC_FIFO_RD_STATS_EN

module async_fifo_rd_stream #(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       level
`ifdef ASYNC_FIFO_RD_STATS_EN
    ,
    output logic [31:0]      pop_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PKT_W-1:0] PKT_MAX = PKT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_ONE   = 2'd1,
        LVL_FULL  = 2'd2
    } level_e;

    level_e           level_q, level_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             pop;
    logic             xfer;

    // The pop decision looks only at FIFO flags and local registers, never at
    // m_ready; the skid entry absorbs the word popped in the cycle the
    // downstream stalls. Gating with rrst_n keeps rinc low while in reset.
    assign pop  = rrst_n & en & ~rempty & (level_q != LVL_FULL) & ~flush;
    assign xfer = (level_q != LVL_EMPTY) & m_ready;

    assign rinc    = pop;
    assign m_valid = (level_q != LVL_EMPTY);
    assign m_data  = head_q;
    assign m_last  = m_valid & (pkt_cnt_q == PKT_MAX);
    assign level   = level_q;

    // Buffer occupancy and data movement. The head register is always the
    // word on m_data; the skid register only holds a word in LVL_FULL.
    always_comb begin
        level_d   = level_q;
        head_d    = head_q;
        skid_d    = skid_q;
        pkt_cnt_d = pkt_cnt_q;

        unique case (level_q)
            LVL_EMPTY: begin
                if (pop) begin
                    head_d  = rdata;
                    level_d = LVL_ONE;
                end
            end
            LVL_ONE: begin
                if (pop && xfer) begin
                    head_d = rdata;
                end else if (pop) begin
                    skid_d  = rdata;
                    level_d = LVL_FULL;
                end else if (xfer) begin
                    level_d = LVL_EMPTY;
                end
            end
            LVL_FULL: begin
                if (xfer) begin
                    head_d  = skid_q;
                    level_d = LVL_ONE;
                end
            end
            default: begin
                level_d = LVL_EMPTY;
            end
        endcase

        if (xfer) begin
            pkt_cnt_d = (pkt_cnt_q == PKT_MAX) ? '0 : pkt_cnt_q + 1'b1;
        end

        // Flush wins over everything: the buffer empties and a transfer
        // happening on the same edge does not advance the packet count.
        if (flush) begin
            level_d   = LVL_EMPTY;
            pkt_cnt_d = '0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            level_q   <= LVL_EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [31:0] pop_cnt_q, pop_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters; only rrst_n clears them, flush does not.
    always_comb begin
        pop_cnt_d   = pop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop && (pop_cnt_q != 32'hFFFF_FFFF)) begin
            pop_cnt_d = pop_cnt_q + 32'd1;
        end
        if (m_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pop_cnt_q   <= pop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pop_cnt   = pop_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb_async_fifo_rd_stream
//
// Directed self-checking bench for async_fifo_rd_stream with PKT_LEN=4.
// A small FIFO model drives rempty/rdata and advances its read pointer on
// every rinc, so popped words and their order are fully known to the bench.

module tb_async_fifo_rd_stream;

    localparam int DSIZE   = 32;
    localparam int PKT_LEN = 4;

    logic             rclk;
    logic             rrst_n;
    logic             en;
    logic             flush;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic [1:0]       level;
`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [31:0]      pop_cnt;
    logic [31:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // FIFO model: words are pushed by the stimulus, popped on rinc.
    logic [DSIZE-1:0] fifo_mem [0:255];
    logic [7:0]       rd_ptr = 8'd0;
    logic [7:0]       wr_ptr = 8'd0;
    logic [7:0]       ptr_mark;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = fifo_mem[rd_ptr];

    always @(posedge rclk) begin
        if (rinc) begin
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    async_fifo_rd_stream #(
        .DSIZE   (DSIZE),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .en        (en),
        .flush     (flush),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .level     (level)
`ifdef ASYNC_FIFO_RD_STATS_EN
        ,
        .pop_cnt   (pop_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Push count consecutive words starting at base into the FIFO model.
    task automatic applyStimulus(input logic [31:0] base, input int count);
        for (int k = 0; k < count; k++) begin
            fifo_mem[wr_ptr] = base + 32'(k);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle flush pulse while the FIFO is empty; clears the packet count.
    task automatic doFlush();
        flush = 1'b1;
        #1;
        checkOutput("flush_rinc", rinc, 0);
        @(negedge rclk);
        flush = 1'b0;
    endtask

    initial begin
        rrst_n  = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        #1;
        checkOutput("rst_rinc", rinc, 0);
        checkOutput("rst_valid", m_valid, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_data", m_data, 0);
        checkOutput("rst_last", m_last, 0);

        repeat (2) @(negedge rclk);
        rrst_n  = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;

        // Idle with the FIFO empty.
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            checkOutput("idle_rinc", rinc, 0);
            checkOutput("idle_valid", m_valid, 0);
            checkOutput("idle_level", level, 0);
            checkOutput("idle_data", m_data, 0);
        end

        // Ten words at full rate, first valid one cycle after the first pop.
        applyStimulus(32'd0, 10);
        #1;
        checkOutput("s10_first_rinc", rinc, 1);
        checkOutput("s10_first_valid", m_valid, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            checkOutput("s10_valid", m_valid, 1);
            checkOutput("s10_data", m_data, 32'(i));
            checkOutput("s10_last", m_last, 32'((i % 4) == 3));
        end
        @(negedge rclk);
        checkOutput("s10_end_valid", m_valid, 0);
        checkOutput("s10_end_level", level, 0);
        checkOutput("s10_end_rinc", rinc, 0);
        doFlush();

        // Backpressure: exactly two pops fill the buffer, head held.
        m_ready  = 1'b0;
        ptr_mark = rd_ptr;
        applyStimulus(32'd200, 5);
        #1;
        checkOutput("bp_rinc0", rinc, 1);
        @(negedge rclk);
        checkOutput("bp_level1", level, 1);
        checkOutput("bp_data0", m_data, 200);
        @(negedge rclk);
        checkOutput("bp_level2", level, 2);
        checkOutput("bp_rinc_full", rinc, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge rclk);
            checkOutput("bp_hold_rinc", rinc, 0);
            checkOutput("bp_hold_level", level, 2);
            checkOutput("bp_hold_valid", m_valid, 1);
            checkOutput("bp_hold_data", m_data, 200);
            checkOutput("bp_hold_last", m_last, 0);
        end
        checkOutput("bp_pops", 32'(rd_ptr - ptr_mark), 2);
        m_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge rclk);
            checkOutput("bp_drain_valid", m_valid, 1);
            checkOutput("bp_drain_data", m_data, 32'(200 + i));
            checkOutput("bp_drain_last", m_last, 32'(i == 3));
        end
        @(negedge rclk);
        checkOutput("bp_end_valid", m_valid, 0);
        doFlush();

        // Twelve words: m_last on words 3, 7 and 11.
        applyStimulus(32'd400, 12);
        for (int i = 0; i < 12; i++) begin
            @(negedge rclk);
            checkOutput("pkt_data", m_data, 32'(400 + i));
            checkOutput("pkt_last", m_last, 32'((i % 4) == 3));
        end
        @(negedge rclk);
        checkOutput("pkt_end_valid", m_valid, 0);

        // Flush with a full buffer and a non-empty FIFO.
        m_ready = 1'b0;
        applyStimulus(32'd300, 6);
        repeat (2) @(negedge rclk);
        checkOutput("fl_pre_level", level, 2);
        ptr_mark = rd_ptr;
        flush    = 1'b1;
        m_ready  = 1'b1;
        #1;
        checkOutput("fl_rinc", rinc, 0);
        @(negedge rclk);
        checkOutput("fl_valid", m_valid, 0);
        checkOutput("fl_level", level, 0);
        checkOutput("fl_no_pop", rd_ptr, ptr_mark);
        flush = 1'b0;
        #1;
        checkOutput("fl_resume_rinc", rinc, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            checkOutput("fl_data", m_data, 32'(302 + i));
            checkOutput("fl_last", m_last, 32'(i == 3));
        end
        @(negedge rclk);
        checkOutput("fl_end_valid", m_valid, 0);

        // en dropped with a full buffer: buffered words still drain.
        m_ready  = 1'b0;
        ptr_mark = rd_ptr;
        applyStimulus(32'd500, 4);
        repeat (2) @(negedge rclk);
        checkOutput("en_level", level, 2);
        en      = 1'b0;
        m_ready = 1'b1;
        @(negedge rclk);
        checkOutput("en_drain_data", m_data, 501);
        checkOutput("en_drain_rinc", rinc, 0);
        @(negedge rclk);
        checkOutput("en_drained_valid", m_valid, 0);
        checkOutput("en_pops", 32'(rd_ptr - ptr_mark), 2);
        en = 1'b1;
        @(negedge rclk);
        checkOutput("en_resume_data", m_data, 502);
        checkOutput("en_resume_last", m_last, 0);
        @(negedge rclk);
        checkOutput("en_resume_data2", m_data, 503);
        checkOutput("en_resume_last2", m_last, 1);
        @(negedge rclk);
        checkOutput("en_end_valid", m_valid, 0);

        // Asynchronous reset in the middle of a cycle with a full buffer.
        m_ready = 1'b0;
        applyStimulus(32'd600, 2);
        repeat (2) @(negedge rclk);
        checkOutput("ar_pre_level", level, 2);
        #2;
        rrst_n = 1'b0;
        #1;
        checkOutput("ar_level", level, 0);
        checkOutput("ar_valid", m_valid, 0);
        checkOutput("ar_data", m_data, 0);
        checkOutput("ar_rinc", rinc, 0);
        @(negedge rclk);
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        applyStimulus(32'd602, 1);
        @(negedge rclk);
        checkOutput("ar_next_data", m_data, 602);
        checkOutput("ar_next_last", m_last, 0);
        @(negedge rclk);
        checkOutput("ar_end_valid", m_valid, 0);

        // Statistics: 6 pops and 3 stalled cycles from a fresh reset.
        rrst_n = 1'b0;
        @(negedge rclk);
        rrst_n  = 1'b1;
        m_ready = 1'b0;
        applyStimulus(32'd700, 6);
        repeat (4) @(negedge rclk);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("st_data", m_data, 32'(700 + i));
            @(negedge rclk);
        end
        checkOutput("st_end_valid", m_valid, 0);
`ifdef ASYNC_FIFO_RD_STATS_EN
        checkOutput("st_pop_cnt", pop_cnt, 6);
        checkOutput("st_stall_cnt", stall_cnt, 3);
        doFlush();
        checkOutput("st_flush_pop_cnt", pop_cnt, 6);
        checkOutput("st_flush_stall_cnt", stall_cnt, 3);
        rrst_n = 1'b0;
        #1;
        checkOutput("st_rst_pop_cnt", pop_cnt, 0);
        checkOutput("st_rst_stall_cnt", stall_cnt, 0);
        @(negedge rclk);
        rrst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
